// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// operand width default, op encodings, FSM states and op decode helpers.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared 2*XLEN accumulator: shift-add for
// multiply, restoring subtract-shift for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic              div_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        // NOTE: every signal gets a value on every path through the block,
        // otherwise synthesis would infer a latch to hold the old value.
        mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        diff    = rem_sh - {1'b0, opnd_i};
        acc_o   = {mul_sum, acc_i[XLEN-1:1]};

        // Divide: upper half is the partial remainder, lower half collects quotient bits.
        if (div_i) begin
            if (diff[XLEN]) begin
                acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; holds the
// upstream pipeline via a combinational stall while an operation is in flight.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            divzero_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   opnd_q;
    logic              div_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              divz_q;

    logic              accept;
    logic              in_div;
    logic              in_divz;
    logic              rs_neg;
    logic              rt_neg;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign accept  = (state_q == IDLE) && start_i && !flush_i;
    assign in_div  = op_is_div(op_i);
    assign in_divz = in_div && (rt_i == '0);
    assign rs_neg  = op_is_signed(op_i) && rs_i[XLEN-1];
    assign rt_neg  = op_is_signed(op_i) && rt_i[XLEN-1];
    assign rs_mag  = rs_neg ? -rs_i : rs_i;
    assign rt_mag  = rt_neg ? -rt_i : rt_i;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (acc_step)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = in_divz ? FIX : CALC;
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                stall_o = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sign fixup: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        fix_hi   = prod_fix[2*XLEN-1:XLEN];
        fix_lo   = prod_fix[XLEN-1:0];
        if (divz_q) begin
            fix_hi = acc_q[2*XLEN-1:XLEN];
            fix_lo = acc_q[XLEN-1:0];
        end else if (div_q) begin
            fix_hi = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            fix_lo = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the wide datapath registers are reset as well so that a
        // discarded operation leaves nothing observable behind.
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            done_o    <= 1'b0;
            divzero_o <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        div_q     <= in_div;
                        divz_q    <= in_divz;
                        neg_res_q <= rs_neg ^ rt_neg;
                        neg_rem_q <= rs_neg;
                        opnd_q    <= in_div ? rt_mag : rs_mag;
                        // Divide by zero preloads the final HI=rs, LO=all-ones result.
                        if (in_divz) begin
                            acc_q <= {rs_i, {XLEN{1'b1}}};
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, (in_div ? rs_mag : rt_mag)};
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (!flush_i) begin
                        hi_o      <= fix_hi;
                        lo_o      <= fix_lo;
                        done_o    <= 1'b1;
                        divzero_o <= divz_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
